// File: rtl/idli_mem_arb_m.sv
// Memory-access sequencer for the idli core: owns the slice counter and
// time-shares the SQI path between instruction fetch and load/store accesses.
module idli_mem_arb_m #(
  parameter int unsigned DUMMY_WORDS = 2
) (
  input  logic        i_top_gck,
  input  logic        i_top_rst_n,
  output logic [1:0]  o_arb_ctr,
  input  logic        i_arb_br_vld,
  input  logic [15:0] i_arb_br_pc,
  input  logic        i_arb_ls_req,
  input  logic        i_arb_ls_wr,
  input  logic [15:0] i_arb_ls_addr,
  input  logic [15:0] i_arb_ls_wdata,
  output logic        o_arb_ls_ack,
  output logic [15:0] o_arb_ls_rdata,
  output logic        o_arb_instr_vld,
  output logic [15:0] o_arb_instr_pc,
  output logic        o_arb_sqi_redirect,
  output logic        o_arb_sqi_wr_en,
  output logic [3:0]  o_arb_sqi_slice,
  input  logic [3:0]  i_arb_sqi_slice
);

  typedef enum logic [2:0] {
    IDLE, F_ADDR, F_WAIT, F_STREAM, D_ADDR, D_WAIT, D_XFER
  } state_t;

  localparam bit         NO_WAIT   = (DUMMY_WORDS == 0);
  localparam logic [1:0] WAIT_LAST = NO_WAIT ? 2'd0 : 2'(DUMMY_WORDS - 1);

  state_t      state_q, state_d;
  logic [1:0]  ctr_q;
  logic [1:0]  wcnt_q;
  logic [15:0] pc_q;
  logic        br_pend_q;
  logic [15:0] br_pc_q;
  logic [11:0] rd_sh_q;
  logic [15:0] rdata_q;
  logic        ack_q;

  logic        word_end;
  logic        br_any;
  logic [15:0] br_tgt;
  logic        instr_vld;
  logic        enter_faddr;

  function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] c);
    case (c)
      2'd0:    return w[3:0];
      2'd1:    return w[7:4];
      2'd2:    return w[11:8];
      default: return w[15:12];
    endcase
  endfunction

  // A branch pulse in the current cycle counts as pending and overrides the latched target.
  assign word_end    = (ctr_q == 2'd3);
  assign br_any      = br_pend_q | i_arb_br_vld;
  assign br_tgt      = i_arb_br_vld ? i_arb_br_pc : br_pc_q;
  assign instr_vld   = (state_q == F_STREAM) && word_end && !br_any;
  assign enter_faddr = word_end && (state_d == F_ADDR);

  always_comb begin
    state_d            = state_q;
    o_arb_sqi_redirect = 1'b0;
    o_arb_sqi_wr_en    = 1'b0;
    o_arb_sqi_slice    = '0;
    case (state_q)
      IDLE: begin
        if (word_end) state_d = F_ADDR;
      end
      F_ADDR: begin
        o_arb_sqi_redirect = 1'b1;
        o_arb_sqi_slice    = nib(pc_q, ctr_q);
        if (word_end) begin
          if (br_any)       state_d = F_ADDR;
          else if (NO_WAIT) state_d = F_STREAM;
          else              state_d = F_WAIT;
        end
      end
      F_WAIT: begin
        if (word_end) begin
          if (br_any)              state_d = F_ADDR;
          else if (wcnt_q == '0)   state_d = F_STREAM;
        end
      end
      F_STREAM: begin
        if (word_end) begin
          if (br_any)            state_d = F_ADDR;
          else if (i_arb_ls_req) state_d = D_ADDR;
        end
      end
      D_ADDR: begin
        o_arb_sqi_redirect = 1'b1;
        o_arb_sqi_wr_en    = i_arb_ls_wr;
        o_arb_sqi_slice    = nib(i_arb_ls_addr, ctr_q);
        if (word_end) state_d = (i_arb_ls_wr || NO_WAIT) ? D_XFER : D_WAIT;
      end
      D_WAIT: begin
        if (word_end && (wcnt_q == '0)) state_d = D_XFER;
      end
      D_XFER: begin
        if (i_arb_ls_wr) begin
          o_arb_sqi_wr_en = 1'b1;
          o_arb_sqi_slice = nib(i_arb_ls_wdata, ctr_q);
        end
        if (word_end) state_d = F_ADDR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_q + 2'd1;
      // Reload on any non-wait word so a fresh wait always starts from the full count.
      if (word_end)
        wcnt_q <= ((state_q == F_WAIT) || (state_q == D_WAIT)) ? wcnt_q - 2'd1 : WAIT_LAST;
    end
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      pc_q      <= '0;
      br_pend_q <= 1'b0;
      br_pc_q   <= '0;
    end else if (enter_faddr) begin
      if (br_any) pc_q <= br_tgt;
      br_pend_q <= 1'b0;
    end else begin
      if (i_arb_br_vld) begin
        br_pend_q <= 1'b1;
        br_pc_q   <= i_arb_br_pc;
      end
      if (instr_vld) pc_q <= pc_q + 16'd1;
    end
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      rd_sh_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= (state_q == D_XFER) && word_end;
      if ((state_q == D_XFER) && !i_arb_ls_wr) begin
        case (ctr_q)
          2'd0:    rd_sh_q[3:0]  <= i_arb_sqi_slice;
          2'd1:    rd_sh_q[7:4]  <= i_arb_sqi_slice;
          2'd2:    rd_sh_q[11:8] <= i_arb_sqi_slice;
          default: rdata_q       <= {i_arb_sqi_slice, rd_sh_q};
        endcase
      end
    end
  end

  assign o_arb_ctr       = ctr_q;
  assign o_arb_ls_ack    = ack_q;
  assign o_arb_ls_rdata  = rdata_q;
  assign o_arb_instr_vld = instr_vld;
  assign o_arb_instr_pc  = pc_q;

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// Directed bench for idli_mem_arb_m with DUMMY_WORDS=2: fetch start, load,
// store, branch redirects, branch/LSU priority, pc wrap and mid-access reset.
module tb_idli_mem_arb_m;

  logic        i_top_gck = 1'b0;
  logic        i_top_rst_n = 1'b0;
  logic [1:0]  o_arb_ctr;
  logic        i_arb_br_vld = 1'b0;
  logic [15:0] i_arb_br_pc = '0;
  logic        i_arb_ls_req = 1'b0;
  logic        i_arb_ls_wr = 1'b0;
  logic [15:0] i_arb_ls_addr = '0;
  logic [15:0] i_arb_ls_wdata = '0;
  logic        o_arb_ls_ack;
  logic [15:0] o_arb_ls_rdata;
  logic        o_arb_instr_vld;
  logic [15:0] o_arb_instr_pc;
  logic        o_arb_sqi_redirect;
  logic        o_arb_sqi_wr_en;
  logic [3:0]  o_arb_sqi_slice;
  logic [3:0]  i_arb_sqi_slice = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  idli_mem_arb_m #(.DUMMY_WORDS(2)) u_dut (
    .i_top_gck          (i_top_gck),
    .i_top_rst_n        (i_top_rst_n),
    .o_arb_ctr          (o_arb_ctr),
    .i_arb_br_vld       (i_arb_br_vld),
    .i_arb_br_pc        (i_arb_br_pc),
    .i_arb_ls_req       (i_arb_ls_req),
    .i_arb_ls_wr        (i_arb_ls_wr),
    .i_arb_ls_addr      (i_arb_ls_addr),
    .i_arb_ls_wdata     (i_arb_ls_wdata),
    .o_arb_ls_ack       (o_arb_ls_ack),
    .o_arb_ls_rdata     (o_arb_ls_rdata),
    .o_arb_instr_vld    (o_arb_instr_vld),
    .o_arb_instr_pc     (o_arb_instr_pc),
    .o_arb_sqi_redirect (o_arb_sqi_redirect),
    .o_arb_sqi_wr_en    (o_arb_sqi_wr_en),
    .o_arb_sqi_slice    (o_arb_sqi_slice),
    .i_arb_sqi_slice    (i_arb_sqi_slice)
  );

  always #5 i_top_gck = ~i_top_gck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] w, input int k);
    return w[4*k +: 4];
  endfunction

  task automatic chk_sqi(input string tag, input logic redir, input logic wr, input logic [3:0] sl);
    check_eq({tag, "_redir"}, o_arb_sqi_redirect, redir);
    check_eq({tag, "_wr"},    o_arb_sqi_wr_en,    wr);
    check_eq({tag, "_slice"}, o_arb_sqi_slice,    sl);
  endtask

  task automatic chk_all_zero(input string tag);
    check_eq({tag, "_ctr"},   o_arb_ctr,       0);
    check_eq({tag, "_ack"},   o_arb_ls_ack,    0);
    check_eq({tag, "_rdata"}, o_arb_ls_rdata,  0);
    check_eq({tag, "_vld"},   o_arb_instr_vld, 0);
    check_eq({tag, "_ipc"},   o_arb_instr_pc,  0);
    chk_sqi(tag, 1'b0, 1'b0, 4'h0);
  endtask

  // Asserts reset immediately, checks outputs, releases on a falling edge (cycle 0).
  task automatic do_reset();
    i_top_rst_n     = 1'b0;
    i_arb_br_vld    = 1'b0;
    i_arb_br_pc     = '0;
    i_arb_ls_req    = 1'b0;
    i_arb_ls_wr     = 1'b0;
    i_arb_ls_addr   = '0;
    i_arb_ls_wdata  = '0;
    i_arb_sqi_slice = '0;
    #1;
    chk_all_zero("rst");
    repeat (3) @(negedge i_top_gck);
    i_top_rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) begin
      @(negedge i_top_gck);
      cyc++;
    end
  endtask

  initial begin
    @(negedge i_top_gck);

    // Fetch start after reset
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      to_cyc(c); #1;
      check_eq("idle_ctr", o_arb_ctr, c % 4);
      check_eq("idle_redir", o_arb_sqi_redirect, (c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) check_eq("idle_slice", o_arb_sqi_slice, 0);
      check_eq("idle_vld", o_arb_instr_vld, (c == 19 || c == 23 || c == 27));
      if (c == 19 || c == 23 || c == 27) check_eq("idle_ipc", o_arb_instr_pc, (c - 19) / 4);
    end

    // Load of 0x1234 returning 0xABCD
    do_reset();
    for (int c = 0; c <= 51; c++) begin
      to_cyc(c);
      if (c == 17) begin i_arb_ls_req = 1'b1; i_arb_ls_wr = 1'b0; i_arb_ls_addr = 16'h1234; end
      if (c == 37) i_arb_ls_req = 1'b0;
      i_arb_sqi_slice = (c >= 32 && c <= 35) ? nib(16'hABCD, c - 32) : 4'h0;
      #1;
      if (c == 19) begin check_eq("ld_vld19", o_arb_instr_vld, 1); check_eq("ld_ipc19", o_arb_instr_pc, 0); end
      if (c == 23) check_eq("ld_vld23", o_arb_instr_vld, 0);
      if (c >= 20 && c <= 23) chk_sqi("ld_addr", 1'b1, 1'b0, nib(16'h1234, c - 20));
      if (c >= 24 && c <= 35) chk_sqi("ld_wait", 1'b0, 1'b0, 4'h0);
      check_eq("ld_ack", o_arb_ls_ack, (c == 36));
      if (c == 36) check_eq("ld_rdata", o_arb_ls_rdata, 16'hABCD);
      if (c >= 36 && c <= 39) chk_sqi("ld_resume", 1'b1, 1'b0, nib(16'h0001, c - 36));
      if (c == 51) begin
        check_eq("ld_vld51", o_arb_instr_vld, 1);
        check_eq("ld_ipc51", o_arb_instr_pc, 1);
        check_eq("ld_rdata_hold", o_arb_ls_rdata, 16'hABCD);
      end
    end

    // Store of 0xBEEF to 0x0010
    do_reset();
    for (int c = 0; c <= 31; c++) begin
      to_cyc(c);
      if (c == 17) begin
        i_arb_ls_req = 1'b1; i_arb_ls_wr = 1'b1;
        i_arb_ls_addr = 16'h0010; i_arb_ls_wdata = 16'hBEEF;
      end
      if (c == 29) i_arb_ls_req = 1'b0;
      #1;
      if (c >= 20 && c <= 23) chk_sqi("st_addr", 1'b1, 1'b1, nib(16'h0010, c - 20));
      if (c >= 24 && c <= 27) chk_sqi("st_data", 1'b0, 1'b1, nib(16'hBEEF, c - 24));
      check_eq("st_ack", o_arb_ls_ack, (c == 28));
      if (c == 28) check_eq("st_rdata", o_arb_ls_rdata, 0);
      if (c >= 28 && c <= 31) chk_sqi("st_resume", 1'b1, 1'b0, nib(16'h0001, c - 28));
    end

    // Two branches back to back in a stream word: latest wins
    do_reset();
    for (int c = 0; c <= 39; c++) begin
      to_cyc(c);
      if (c == 21) begin i_arb_br_vld = 1'b1; i_arb_br_pc = 16'h0040; end
      if (c == 22) i_arb_br_pc = 16'h0080;
      if (c == 23) i_arb_br_vld = 1'b0;
      #1;
      if (c == 19) check_eq("br_vld19", o_arb_instr_vld, 1);
      if (c >= 20 && c <= 38) check_eq("br_novld", o_arb_instr_vld, 0);
      if (c >= 24 && c <= 27) chk_sqi("br_addr", 1'b1, 1'b0, nib(16'h0080, c - 24));
      if (c == 39) begin check_eq("br_vld39", o_arb_instr_vld, 1); check_eq("br_ipc39", o_arb_instr_pc, 16'h0080); end
    end

    // Branch during a load waits, then the resume fetch uses its target
    do_reset();
    for (int c = 0; c <= 51; c++) begin
      to_cyc(c);
      if (c == 17) begin i_arb_ls_req = 1'b1; i_arb_ls_wr = 1'b0; i_arb_ls_addr = 16'h1234; end
      if (c == 26) begin i_arb_br_vld = 1'b1; i_arb_br_pc = 16'h0200; end
      if (c == 27) i_arb_br_vld = 1'b0;
      if (c == 37) i_arb_ls_req = 1'b0;
      i_arb_sqi_slice = (c >= 32 && c <= 35) ? nib(16'h5A5A, c - 32) : 4'h0;
      #1;
      if (c >= 26 && c <= 35) check_eq("bl_redir", o_arb_sqi_redirect, 0);
      check_eq("bl_ack", o_arb_ls_ack, (c == 36));
      if (c == 36) check_eq("bl_rdata", o_arb_ls_rdata, 16'h5A5A);
      if (c >= 36 && c <= 39) chk_sqi("bl_resume", 1'b1, 1'b0, nib(16'h0200, c - 36));
      if (c == 51) begin check_eq("bl_vld51", o_arb_instr_vld, 1); check_eq("bl_ipc51", o_arb_instr_pc, 16'h0200); end
    end

    // Branch and ls_req together at a boundary; branch to 0xFFFF wraps pc
    do_reset();
    for (int c = 0; c <= 75; c++) begin
      to_cyc(c);
      if (c == 21) begin i_arb_ls_req = 1'b1; i_arb_ls_wr = 1'b0; i_arb_ls_addr = 16'h0003; end
      if (c == 23) begin i_arb_br_vld = 1'b1; i_arb_br_pc = 16'hFFFF; end
      if (c == 24) i_arb_br_vld = 1'b0;
      if (c == 57) i_arb_ls_req = 1'b0;
      i_arb_sqi_slice = (c >= 52 && c <= 55) ? nib(16'h8765, c - 52) : 4'h0;
      #1;
      if (c == 23) check_eq("pr_vld23", o_arb_instr_vld, 0);
      if (c >= 24 && c <= 27) chk_sqi("pr_faddr", 1'b1, 1'b0, 4'hF);
      if (c == 39) begin check_eq("pr_vld39", o_arb_instr_vld, 1); check_eq("pr_ipc39", o_arb_instr_pc, 16'hFFFF); end
      if (c >= 40 && c <= 43) chk_sqi("pr_daddr", 1'b1, 1'b0, nib(16'h0003, c - 40));
      check_eq("pr_ack", o_arb_ls_ack, (c == 56));
      if (c == 56) check_eq("pr_rdata", o_arb_ls_rdata, 16'h8765);
      if (c >= 56 && c <= 59) chk_sqi("pr_resume", 1'b1, 1'b0, 4'h0);
      if (c == 71) begin check_eq("pr_vld71", o_arb_instr_vld, 1); check_eq("pr_ipc71", o_arb_instr_pc, 16'h0000); end
      if (c == 75) begin check_eq("pr_vld75", o_arb_instr_vld, 1); check_eq("pr_ipc75", o_arb_instr_pc, 16'h0001); end
    end

    // Reset asserted in D_WAIT aborts the load with no ack
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      to_cyc(c);
      if (c == 17) begin i_arb_ls_req = 1'b1; i_arb_ls_wr = 1'b0; i_arb_ls_addr = 16'h1234; end
      #1;
      if (c == 26) begin
        check_eq("ra_pc_before", o_arb_instr_pc, 1);
        check_eq("ra_ctr_before", o_arb_ctr, 2);
      end
    end
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      to_cyc(c); #1;
      check_eq("ra_noack", o_arb_ls_ack, 0);
      if (c >= 4 && c <= 7) chk_sqi("ra_faddr", 1'b1, 1'b0, 4'h0);
      if (c == 19) begin check_eq("ra_vld19", o_arb_instr_vld, 1); check_eq("ra_ipc19", o_arb_instr_pc, 0); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idli_mem_arb_m.md
# idli_mem_arb_m

Memory-access sequencer for the idli core. It owns the free-running 2-bit slice counter and drives the SQI memory block's redirect, write-enable and slice inputs. It shares that single memory path between sequential instruction fetch and load/store data accesses, applying branch redirects. It sits between the core control/LSU logic and `idli_sqi_m` inside the top level.

## Interface
Parameters:
- DUMMY_WORDS, default 2: number of 4-cycle word periods between the end of a read address and the first read data word; legal range 0–3.

Ports:
- i_top_gck  input  1  core clock; all state on its rising edge.
- i_top_rst_n  input  1  asynchronous, active-low reset.
- o_arb_ctr  output  2  slice counter, free-running 0→1→2→3→0.
- i_arb_br_vld  input  1  branch redirect request, single-cycle pulse.
- i_arb_br_pc  input  16  branch target word address, valid with i_arb_br_vld.
- i_arb_ls_req  input  1  load/store request; held high until o_arb_ls_ack.
- i_arb_ls_wr  input  1  1 = store, 0 = load; stable while i_arb_ls_req is high.
- i_arb_ls_addr  input  16  data word address; stable while i_arb_ls_req is high.
- i_arb_ls_wdata  input  16  store data; stable while i_arb_ls_req is high.
- o_arb_ls_ack  output  1  one-cycle completion pulse.
- o_arb_ls_rdata  output  16  load data, valid with o_arb_ls_ack and held until the next load completes.
- o_arb_instr_vld  output  1  the SQI instruction word is valid for the core.
- o_arb_instr_pc  output  16  address of the word flagged by o_arb_instr_vld.
- o_arb_sqi_redirect  output  1  to SQI redirect; an address is being sent.
- o_arb_sqi_wr_en  output  1  to SQI write enable.
- o_arb_sqi_slice  output  4  to SQI slice input; address or store data.
- i_arb_sqi_slice  input  4  from SQI slice output; read data.

## Operation
- Words are transferred as 4 slices, LSB first. At ctr=c, slice = bits [4c+3:4c].
- All state transitions occur only at the end of a word (ctr=3). Every state therefore lasts a whole number of words aligned to ctr=0.
- States and per-state outputs:
  - IDLE: all SQI outputs 0.
  - F_ADDR: redirect=1, wr_en=0, slice=pc slices.
  - F_WAIT: redirect=0; remaining-word counter counts down.
  - F_STREAM: each word is one fetched instruction.
  - D_ADDR: redirect=1, wr_en=ls_wr, slice=ls_addr slices.
  - D_WAIT: redirect=0, wr_en=0.
  - D_XFER: a store drives wr_en=1 and wdata slices; a load captures i_arb_sqi_slice into rdata.
- Transitions:
  - IDLE → F_ADDR.
  - F_ADDR → F_WAIT, or → F_STREAM if DUMMY_WORDS=0.
  - F_WAIT → F_STREAM after DUMMY_WORDS words.
  - F_STREAM at word end:
    - If a branch is pending → F_ADDR.
    - Else if ls_req → D_ADDR.
    - Else stay in F_STREAM.
  - D_ADDR → D_XFER for a store, or when DUMMY_WORDS=0; otherwise → D_WAIT.
  - D_WAIT → D_XFER after DUMMY_WORDS words.
  - D_XFER → F_ADDR.
- Fetch PC:
  - Reset value is 0.
  - It increments at the end of each F_STREAM word in which no branch is pending, wrapping 0xFFFF→0x0000.
- Branches:
  - i_arb_br_vld latches br_pc into a pending register. A later pulse overwrites it; the latest branch wins.
  - The pending branch is consumed on entry to F_ADDR, which loads pc ← pending pc.
  - A branch arriving in F_ADDR or F_WAIT forces the next state to F_ADDR, aborting the fetch stream.
  - A branch arriving during D_ADDR, D_WAIT or D_XFER waits; the resume F_ADDR uses the branch target.
- Instruction valid:
  - o_arb_instr_vld is high only at ctr=3 of an F_STREAM word with no branch pending, counting a branch pulse arriving in that same cycle.
  - o_arb_instr_pc = pc during that cycle.
- Branch takes priority over ls_req. An LSU grant always resumes fetch via F_ADDR, so at least one fetch word is delivered between consecutive LSU grants.
- A reset mid-operation aborts any transfer: no ack is issued, and the pending branch and pc are cleared.

## Timing
- Reset values:
  - ctr = 0, state IDLE, pc = 0, no branch pending.
  - All outputs 0, including rdata = 0x0000.
- Cycle 0 is the first edge after reset release.
- Fetch start latency: 4 + 4 + 4·DUMMY_WORDS cycles to the first stream word. The first o_arb_instr_vld follows 3 cycles later.
- o_arb_ls_ack pulses in the cycle after D_XFER ends (ctr=0), in the same cycle as the first F_ADDR cycle. o_arb_ls_rdata updates in that cycle.
- Load occupancy: (2 + DUMMY_WORDS) words. Store occupancy: 2 words.
- The requester may drop i_arb_ls_req in the cycle after the ack. If ls_req is still high at the next F_STREAM boundary, it is treated as a new request.

## Test plan
- Reset then idle, DUMMY_WORDS=2:
  - Cycles 4–7: redirect=1 with slices 0,0,0,0.
  - o_arb_instr_vld at cycles 19, 23, 27 with pc 0, 1, 2.
- Load at 0x1234 raised at cycle 17:
  - Cycles 20–23: D_ADDR with slices 4,3,2,1, wr_en=0.
  - Cycles 32–35: drive read slices 0xD,0xC,0xB,0xA.
  - Cycle 36: ack with rdata=0xABCD; resume F_ADDR with pc=1 on cycles 36–39.
- Store 0xBEEF to 0x0010 at cycle 17:
  - Cycles 20–23: wr_en=1 with slices 0,1,0,0.
  - Cycles 24–27: wr_en=1 with slices F,E,E,B.
  - Cycle 28: ack.
- Branch handling:
  - br_vld to 0x0040 at cycle 21 then to 0x0080 at cycle 22: no instr_vld at 23; cycles 24–27 send 0x0080.
  - Branch arriving during a load: resume F_ADDR uses the branch target.
- Simultaneous branch and ls_req at a stream boundary: branch is served first; the LSU is granted only after one fetch word. PC wrap: branch to 0xFFFF gives instr_pc 0xFFFF then 0x0000.
- Assert reset during D_WAIT: all outputs return to 0 immediately, no ack is issued, and fetch restarts from pc 0.
